// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and the byte-lane mask helper for dmem_slave.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Lanes that cross the 8-byte boundary are shifted out; such accesses fault anyway.
   function automatic logic [7:0] size_to_mask(input size_e size, input logic [2:0] off);
      logic [15:0] w_m;
      case (size)
         SZ_B:    w_m = 16'h0001;
         SZ_H:    w_m = 16'h0003;
         SZ_W:    w_m = 16'h000F;
         default: w_m = 16'h00FF;
      endcase
      w_m = w_m << off;
      return w_m[7:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH x 64-bit RAM, byte write enables, combinational read.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_array #(
   parameter int DEPTH = 1024,
   parameter int IDXW  = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic [IDXW-1:0] i_idx,
   input  logic [7:0]      i_be,
   input  logic [63:0]     i_wdata,
   output logic [63:0]     o_rdata
);

   logic [63:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (i_be[b]) begin
            r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

`default_nettype wire

// File: rtl/dmem_slave.sv
// ============================================================================
//  Module      : dmem_slave
//  Description : Load/store responder with programmable response latency.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_slave
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int c_IDXW = $clog2(DEPTH);
   localparam int c_CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [c_CNTW-1:0] c_CNT_INIT = c_CNTW'(LATENCY - 1);
   localparam logic [c_CNTW-1:0] c_CNT_ONE  = c_CNTW'(1);

   state_e            r_state;
   logic [c_CNTW-1:0] r_cnt;
   logic              r_wen;
   logic [63:0]       r_addr;
   size_e             r_size;
   logic [63:0]       r_wdata;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic [63:0]       r_rsp_rdata;
   logic              r_rsp_err;

   logic              w_enter_resp;
   logic              w_wen;
   logic [63:0]       w_addr;
   size_e             w_size;
   logic [63:0]       w_wdata;
   logic [2:0]        w_off;
   logic [c_IDXW-1:0] w_idx;
   logic [3:0]        w_nbytes;
   logic              w_fault;
   logic [7:0]        w_be;
   logic [63:0]       w_wdata_sh;
   logic [63:0]       w_rword;
   logic [63:0]       w_keep;
   logic [63:0]       w_rsp_data;

   // With LATENCY==1 RESP is entered on the accept edge, so the live request drives the array.
   assign w_enter_resp = (r_state == IDLE && req_valid && LATENCY == 1) ||
                         (r_state == WAIT && r_cnt == c_CNT_ONE);
   assign w_wen   = (r_state == IDLE) ? req_wen           : r_wen;
   assign w_addr  = (r_state == IDLE) ? req_addr          : r_addr;
   assign w_size  = (r_state == IDLE) ? size_e'(req_size) : r_size;
   assign w_wdata = (r_state == IDLE) ? req_wdata         : r_wdata;

   assign w_off      = w_addr[2:0];
   assign w_idx      = w_addr[c_IDXW+2:3];
   assign w_nbytes   = 4'd1 << w_size;
   assign w_fault    = (({1'b0, w_off} + w_nbytes) > 4'd8) || (|w_addr[63:c_IDXW+3]);
   assign w_be       = (rst_n && w_enter_resp && w_wen && !w_fault) ? size_to_mask(w_size, w_off) : 8'h00;
   assign w_wdata_sh = w_wdata << {w_off, 3'b000};

   always_comb begin
      w_keep = 64'hFFFF_FFFF_FFFF_FFFF;
      case (w_size)
         SZ_B:    w_keep = 64'h0000_0000_0000_00FF;
         SZ_H:    w_keep = 64'h0000_0000_0000_FFFF;
         SZ_W:    w_keep = 64'h0000_0000_FFFF_FFFF;
         default: w_keep = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   end

   assign w_rsp_data = (w_wen || w_fault) ? 64'd0 : ((w_rword >> {w_off, 3'b000}) & w_keep);

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .i_idx   (w_idx),
      .i_be    (w_be),
      .i_wdata (w_wdata_sh),
      .o_rdata (w_rword)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 64'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_wen       <= req_wen;
                  r_addr      <= req_addr;
                  r_size      <= size_e'(req_size);
                  r_wdata     <= req_wdata;
                  r_cnt       <= c_CNT_INIT;
                  r_req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdata <= w_rsp_data;
                     r_rsp_err   <= w_fault;
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (r_cnt == c_CNT_ONE) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= w_rsp_data;
                  r_rsp_err   <= w_fault;
               end else begin
                  r_cnt <= r_cnt - c_CNT_ONE;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_req_ready <= 1'b1;
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdata <= 64'd0;
                  r_rsp_err   <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_rsp_rdata <= 64'd0;
               r_rsp_err   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_slave.sv
// ============================================================================
//  Module      : tb_dmem_slave
//  Description : Directed bench; instance g of the DUT has LATENCY = g+1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_slave;
   import dmem_pkg::*;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n     [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_wen   [3];
   logic [63:0] req_addr  [3];
   logic [1:0]  req_size  [3];
   logic [63:0] req_wdata [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [63:0] rsp_rdata [3];
   logic        rsp_err   [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_slave #(
         .DEPTH   (DEPTH),
         .LATENCY (g + 1)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_wen   (req_wen[g]),
         .req_addr  (req_addr[g]),
         .req_size  (req_size[g]),
         .req_wdata (req_wdata[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g])
      );
   end

   // Runs one request with rsp_ready held high; lat = edges from accept to the edge seeing rsp_valid, -1 on timeout.
   task automatic xact(input int k, input logic wen, input logic [63:0] addr, input logic [1:0] size,
                       input logic [63:0] wdata, output logic [63:0] rdata, output logic err, output int lat);
      int n;
      @(negedge clk);
      req_valid[k] = 1'b1; req_wen[k] = wen; req_addr[k] = addr;
      req_size[k] = size; req_wdata[k] = wdata; rsp_ready[k] = 1'b1;
      n = 0;
      while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      req_valid[k] = 1'b0; req_wen[k] = ~wen; req_addr[k] = ~addr;
      req_size[k] = ~size; req_wdata[k] = ~wdata;
      lat = 1;
      while (!rsp_valid[k] && lat < 50) begin @(negedge clk); lat++; end
      rdata = rsp_rdata[k];
      err   = rsp_err[k];
      if (n >= 50 || lat >= 50) lat = -1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_addr[k] = 64'd0;
         req_size[k] = 2'd0; req_wdata[k] = 64'd0; rsp_ready[k] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         total++; if (req_ready[k] !== 1'b1) begin bad++; $display("FAIL reset_req_ready[%0d] got=%b exp=1", k, req_ready[k]); end
         total++; if (rsp_valid[k] !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid[%0d] got=%b exp=0", k, rsp_valid[k]); end
         total++; if (rsp_rdata[k] !== 64'd0) begin bad++; $display("FAIL reset_rsp_rdata[%0d] got=%h exp=0", k, rsp_rdata[k]); end
         total++; if (rsp_err[k] !== 1'b0) begin bad++; $display("FAIL reset_rsp_err[%0d] got=%b exp=0", k, rsp_err[k]); end
         rst_n[k] = 1'b1;
      end
   endtask

   task automatic test_store_load();
      logic [63:0] rd; logic er; int lat;
      xact(1, 1'b1, 64'h10, SZ_D, 64'h1122334455667788, rd, er, lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL st_d_latency got=%0d exp=2", lat); end
      total++; if (er !== 1'b0 || rd !== 64'd0) begin bad++; $display("FAIL st_d_rsp got err=%b data=%h exp err=0 data=0", er, rd); end
      xact(1, 1'b0, 64'h10, SZ_D, 64'h0, rd, er, lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL ld_d_latency got=%0d exp=2", lat); end
      total++; if (rd !== 64'h1122334455667788) begin bad++; $display("FAIL ld_d_data got=%h exp=1122334455667788", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL ld_d_err got=%b exp=0", er); end
   endtask

   task automatic test_byte_merge();
      logic [63:0] rd; logic er; int lat;
      xact(1, 1'b1, 64'h13, SZ_B, 64'hFFFF_FFFF_FFFF_FFAB, rd, er, lat);
      total++; if (er !== 1'b0) begin bad++; $display("FAIL st_b_err got=%b exp=0", er); end
      xact(1, 1'b0, 64'h10, SZ_D, 64'h0, rd, er, lat);
      total++; if (rd !== 64'h11223344AB667788) begin bad++; $display("FAIL merge_d_data got=%h exp=11223344ab667788", rd); end
      xact(1, 1'b0, 64'h12, SZ_H, 64'h0, rd, er, lat);
      total++; if (rd !== 64'h000000000000AB66) begin bad++; $display("FAIL ld_h_data got=%h exp=000000000000ab66", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL ld_h_err got=%b exp=0", er); end
   endtask

   task automatic test_faults();
      logic [63:0] rd; logic er; int lat;
      xact(1, 1'b1, 64'h0, SZ_D, 64'h0123456789ABCDEF, rd, er, lat);
      xact(1, 1'b0, 64'h0E, SZ_W, 64'h0, rd, er, lat);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL cross_err got=%b exp=1", er); end
      total++; if (rd !== 64'd0) begin bad++; $display("FAIL cross_data got=%h exp=0", rd); end
      total++; if (lat !== 2) begin bad++; $display("FAIL cross_latency got=%0d exp=2", lat); end
      xact(1, 1'b1, 64'(DEPTH * 8), SZ_D, 64'hDEAD_BEEF_DEAD_BEEF, rd, er, lat);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL range_err got=%b exp=1", er); end
      xact(1, 1'b0, 64'h0, SZ_D, 64'h0, rd, er, lat);
      total++; if (rd !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL word0_kept got=%h exp=0123456789abcdef", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL word0_err got=%b exp=0", er); end
   endtask

   task automatic test_stall();
      logic [63:0] rd; logic er; int lat; int n;
      @(negedge clk);
      req_valid[1] = 1'b1; req_wen[1] = 1'b0; req_addr[1] = 64'h10; req_size[1] = SZ_D; rsp_ready[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      // A competing store of zeros stays asserted for the whole stall.
      req_wen[1] = 1'b1; req_wdata[1] = 64'd0;
      n = 0;
      while (!rsp_valid[1] && n < 50) begin @(negedge clk); n++; end
      total++; if (n >= 50) begin bad++; $display("FAIL stall_rsp_timeout got=%0d exp<50", n); end
      for (int i = 0; i < 5; i++) begin
         total++; if (rsp_valid[1] !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, rsp_valid[1]); end
         total++; if (rsp_rdata[1] !== 64'h11223344AB667788) begin bad++; $display("FAIL stall_data[%0d] got=%h exp=11223344ab667788", i, rsp_rdata[1]); end
         total++; if (req_ready[1] !== 1'b0) begin bad++; $display("FAIL stall_req_ready[%0d] got=%b exp=0", i, req_ready[1]); end
         @(negedge clk);
      end
      rsp_ready[1] = 1'b1; req_valid[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++; if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin bad++; $display("FAIL stall_release got valid=%b ready=%b exp valid=0 ready=1", rsp_valid[1], req_ready[1]); end
      xact(1, 1'b0, 64'h10, SZ_D, 64'h0, rd, er, lat);
      total++; if (rd !== 64'h11223344AB667788) begin bad++; $display("FAIL stall_no_second got=%h exp=11223344ab667788", rd); end
   endtask

   task automatic test_reset_inflight();
      logic [63:0] rd; logic er; int lat;
      xact(2, 1'b1, 64'h20, SZ_D, 64'h5555666677778888, rd, er, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL lat3_store got=%0d exp=3", lat); end
      @(negedge clk);
      req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 64'h20; req_size[2] = SZ_D; req_wdata[2] = 64'hFF;
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0; rst_n[2] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n[2] = 1'b1;
      total++; if (req_ready[2] !== 1'b1) begin bad++; $display("FAIL rst_mid_req_ready got=%b exp=1", req_ready[2]); end
      total++; if (rsp_valid[2] !== 1'b0 || rsp_rdata[2] !== 64'd0 || rsp_err[2] !== 1'b0) begin
         bad++; $display("FAIL rst_mid_rsp got valid=%b data=%h err=%b exp 0/0/0", rsp_valid[2], rsp_rdata[2], rsp_err[2]); end
      repeat (4) @(negedge clk);
      total++; if (rsp_valid[2] !== 1'b0) begin bad++; $display("FAIL rst_mid_no_rsp got=%b exp=0", rsp_valid[2]); end
      xact(2, 1'b0, 64'h20, SZ_D, 64'h0, rd, er, lat);
      total++; if (rd !== 64'h5555666677778888) begin bad++; $display("FAIL rst_mid_dropped got=%h exp=5555666677778888", rd); end
      total++; if (lat !== 3) begin bad++; $display("FAIL lat3_load got=%0d exp=3", lat); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] rd; logic er; int lat; int acc; int rsp; int both;
      xact(0, 1'b1, 64'h8, SZ_D, 64'hCAFEF00DDEADBEEF, rd, er, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL lat1_store got=%0d exp=1", lat); end
      xact(0, 1'b0, 64'hC, SZ_W, 64'h0, rd, er, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL lat1_load got=%0d exp=1", lat); end
      total++; if (rd !== 64'h00000000CAFEF00D) begin bad++; $display("FAIL lat1_ld_w got=%h exp=00000000cafef00d", rd); end
      req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 64'h30; req_size[0] = SZ_D;
      req_wdata[0] = 64'h1; rsp_ready[0] = 1'b1;
      acc = 0; rsp = 0; both = 0;
      for (int i = 0; i < 20; i++) begin
         if (req_ready[0]) acc++;
         if (rsp_valid[0]) rsp++;
         if (req_ready[0] && rsp_valid[0]) both++;
         @(negedge clk);
      end
      req_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (acc !== 10) begin bad++; $display("FAIL b2b_accepts got=%0d exp=10", acc); end
      total++; if (rsp !== 10) begin bad++; $display("FAIL b2b_responses got=%0d exp=10", rsp); end
      total++; if (both !== 0) begin bad++; $display("FAIL b2b_overlap got=%0d exp=0", both); end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_byte_merge();
      test_faults();
      test_stall();
      test_reset_inflight();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
